sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Framed serial-to-parallel receive controller.
- Detects a start bit on the serial line and shifts WIDTH data bits into an internal register, one bit per bit-rate strobe. It then checks the stop bit and presents the word on a parallel port with a valid/ready handshake.
- Sits between a serial input pin and the parallel consumer. It owns the sequencing of the shift register, so the shift register never shifts free-running.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32).
- LSB_FIRST, 1: 1 = first received data bit lands in po[0]; 0 = first bit lands in po[WIDTH-1].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- bit_en  input  1  bit-rate strobe; the serial line is sampled only on edges where bit_en=1.
- si  input  1  serial data in; idle level is 1.
- po  output  WIDTH  parallel word out.
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po.
- busy  output  1  frame in progress (SHIFT or STOP state).
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  sticky: complete frame dropped because the output buffer was full.
- clr_ovr  input  1  clears overrun.

Behaviour:
- Reset: reset=0 forces, asynchronously, state=IDLE, bit counter=0, shift register=0, po=0, po_valid=0, frame_err=0, overrun=0.
  - A reset asserted mid-frame aborts the frame with no error reported.
- bit_en=0: state, counter and shift register hold; the handshake still operates.
- FSM states: IDLE, SHIFT, STOP.
  - IDLE: on bit_en with si=0 (start bit), go to SHIFT with counter=0. si=1 stays in IDLE.
  - SHIFT: on each bit_en, sample si into the shift register and increment the counter.
    - LSB_FIRST=1: shift right, si enters the MSB.
    - LSB_FIRST=0: shift left, si enters the LSB.
    - After the WIDTH-th sample (counter = WIDTH-1 at that edge), go to STOP.
  - STOP: on bit_en, sample the stop bit and always return to IDLE.
    - si=1 with buffer free: load po from the shift register and set po_valid=1.
    - si=1 with buffer occupied: set overrun; po and po_valid are unchanged and the word is discarded.
    - si=0: frame_err=1 for exactly one clk cycle; the word is discarded; po and po_valid are unchanged.
- Buffer free means: po_valid=0, or po_valid=1 and po_ready=1 on the same edge.
  - In the second case (simultaneous consume and load), the new word is loaded, po_valid stays 1 and no overrun is raised.
- Latency: po_valid rises on the stop-bit sampling edge; it is visible in the cycle following that edge.
- Handshake:
  - A transfer occurs on a rising edge with po_valid=1 and po_ready=1.
  - po is stable while po_valid=1.
  - po_valid clears after the transfer unless a new word loads on the same edge.
  - po_ready while po_valid=0 has no effect.
- overrun:
  - Set on a dropped frame; stays 1 until clr_ovr=1 on an edge.
  - Simultaneous set and clr_ovr: set wins.
- busy=1 in SHIFT and STOP; 0 in IDLE.
- The data bits are not interpreted: a 0 data bit never restarts framing.
- After STOP, a back-to-back start bit is accepted on the next bit_en.

Test Plan:
- Basic frame (WIDTH=8, LSB_FIRST=1, bit_en every cycle, po_ready=0): send si = 0, 1,0,1,0,0,1,0,1, then 1 -> po=0xA5 and po_valid=1 after the stop edge. Both hold for 20 idle cycles; busy is 1 for exactly 9 cycles.
- Handshake and back-to-back: po_ready=1 permanently, send frames 0x3C then 0xC3 with no idle gap -> two single-cycle po_valid pulses with po=0x3C then 0xC3; overrun=0.
- Overrun: po_ready=0, send 0x11 then 0x22 -> po stays 0x11 and overrun=1. Then clr_ovr=1 for one cycle -> overrun=0. Then po_ready=1 for one cycle -> po_valid=0.
- Simultaneous consume/load: po holds 0x11; assert po_ready on the exact stop edge of frame 0x22 -> po=0x22, po_valid stays 1, overrun=0.
- Framing error and strobe gating: stop bit = 0 -> frame_err high for one cycle, po_valid stays 0, FSM returns to IDLE. Repeat a valid 0x5A frame with bit_en asserted every 4th cycle -> po=0x5A; state frozen on non-strobe cycles.
- Reset mid-frame and MSB-first:
  - Drop reset after 4 data bits -> all outputs 0 immediately, no frame_err; the next full frame 0x96 is received correctly.
  - With LSB_FIRST=0, sending bits 1,0,0,1,0,1,1,0 -> po=0x96.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits, stop bit,
// then a valid/ready handshake on the parallel word.
`timescale 1ns/1ps
module sipo_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  state_t           state, nextState;
  logic [CW-1:0]    bitCnt;
  logic [WIDTH-1:0] shiftReg;
  logic             startEn, shiftEn, stopEn;
  logic             bufFree, loadWord, dropWord, badStop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // The buffer counts as free when the consumer takes the old word on this same edge.
  always_comb begin
    nextState = state;
    startEn   = 1'b0;
    shiftEn   = 1'b0;
    stopEn    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && !si) begin
          startEn   = 1'b1;
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (bit_en) begin
          shiftEn = 1'b1;
          if (bitCnt == LAST) nextState = STOP;
        end
      end
      STOP: begin
        busy = 1'b1;
        if (bit_en) begin
          stopEn    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    bufFree  = !po_valid || po_ready;
    loadWord = stopEn && si && bufFree;
    dropWord = stopEn && si && !bufFree;
    badStop  = stopEn && !si;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCnt   <= '0;
      shiftReg <= '0;
    end else if (startEn) begin
      bitCnt <= '0;
    end else if (shiftEn) begin
      bitCnt   <= bitCnt + CW'(1);
      shiftReg <= LSB_FIRST ? {si, shiftReg[WIDTH-1:1]} : {shiftReg[WIDTH-2:0], si};
    end
  end

  // Set of overrun wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      po        <= '0;
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= badStop;
      if (loadWord) begin
        po       <= shiftReg;
        po_valid <= 1'b1;
      end else if (po_valid && po_ready) begin
        po_valid <= 1'b0;
      end
      if (dropWord)     overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: an LSB-first instance checked against
// a frame table plus hand sequences, and an MSB-first instance on the same line.
`timescale 1ns/1ps
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, bit_en, si, po_ready, clr_ovr;
  logic [7:0] po, po2;
  logic       po_valid, busy, frame_err, overrun;
  logic       po_valid2, busy2, frame_err2, overrun2;

  int total = 0;
  int bad   = 0;
  int busyCycles  = 0;
  int validCycles = 0;

  logic [7:0] obsPo, obsPo2;
  logic       obsValid, obsValid2, obsOvr, obsFerr;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       rdyAtStop;
    int         gap;
    logic       clrAfter;
    logic       consumeAfter;
    logic [7:0] expPo;
    logic       expValid;
    logic       expOvr;
    logic       expFerr;
  } vec_t;

  vec_t vecs[6];

  sipo_frame_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .si(si),
    .po(po), .po_valid(po_valid), .po_ready(po_ready), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  sipo_frame_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) dutMsb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .si(si),
    .po(po2), .po_valid(po_valid2), .po_ready(po_ready), .busy(busy2),
    .frame_err(frame_err2), .overrun(overrun2), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy)     busyCycles  <= busyCycles + 1;
    if (po_valid) validCycles <= validCycles + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b, input int gap, input logic expBusy);
    si     = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    si     = 1'b1;
    for (int i = 0; i < gap; i++) begin
      tick();
      checkOutput("gap_busy", {31'd0, busy}, {31'd0, expBusy});
    end
  endtask

  // One full frame; outputs are captured right after the stop-bit edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic rdyAtStop, input int gap, input logic msbOrder);
    sendBit(1'b0, gap, 1'b1);
    for (int i = 0; i < 8; i++)
      sendBit(msbOrder ? data[7-i] : data[i], gap, 1'b1);
    if (rdyAtStop) po_ready = 1'b1;
    sendBit(stopBit, 0, 1'b0);
    obsPo     = po;
    obsValid  = po_valid;
    obsOvr    = overrun;
    obsFerr   = frame_err;
    obsPo2    = po2;
    obsValid2 = po_valid2;
    if (rdyAtStop) po_ready = 1'b0;
  endtask

  initial begin
    int base;
    vecs[0] = '{data:8'h11, stopBit:1'b1, rdyAtStop:1'b0, gap:0, clrAfter:1'b0, consumeAfter:1'b0,
                expPo:8'h11, expValid:1'b1, expOvr:1'b0, expFerr:1'b0};
    vecs[1] = '{data:8'h22, stopBit:1'b1, rdyAtStop:1'b0, gap:0, clrAfter:1'b1, consumeAfter:1'b1,
                expPo:8'h11, expValid:1'b1, expOvr:1'b1, expFerr:1'b0};
    vecs[2] = '{data:8'h11, stopBit:1'b1, rdyAtStop:1'b0, gap:0, clrAfter:1'b0, consumeAfter:1'b0,
                expPo:8'h11, expValid:1'b1, expOvr:1'b0, expFerr:1'b0};
    vecs[3] = '{data:8'h22, stopBit:1'b1, rdyAtStop:1'b1, gap:0, clrAfter:1'b0, consumeAfter:1'b1,
                expPo:8'h22, expValid:1'b1, expOvr:1'b0, expFerr:1'b0};
    vecs[4] = '{data:8'hFF, stopBit:1'b0, rdyAtStop:1'b0, gap:0, clrAfter:1'b0, consumeAfter:1'b0,
                expPo:8'h22, expValid:1'b0, expOvr:1'b0, expFerr:1'b1};
    vecs[5] = '{data:8'h5A, stopBit:1'b1, rdyAtStop:1'b0, gap:3, clrAfter:1'b0, consumeAfter:1'b0,
                expPo:8'h5A, expValid:1'b1, expOvr:1'b0, expFerr:1'b0};

    reset = 1'b0; bit_en = 1'b0; si = 1'b1; po_ready = 1'b0; clr_ovr = 1'b0;
    repeat (2) tick();
    checkOutput("rst_po",       {24'd0, po},         32'h0);
    checkOutput("rst_po_valid", {31'd0, po_valid},   32'h0);
    checkOutput("rst_busy",     {31'd0, busy},       32'h0);
    checkOutput("rst_ferr",     {31'd0, frame_err},  32'h0);
    checkOutput("rst_ovr",      {31'd0, overrun},    32'h0);
    reset = 1'b1;
    tick();

    $display("[TB] basic frame 0xA5");
    base = busyCycles;
    applyStimulus(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("basic_po",    {24'd0, obsPo},    32'hA5);
    checkOutput("basic_valid", {31'd0, obsValid}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("hold_po",    {24'd0, po},       32'hA5);
      checkOutput("hold_valid", {31'd0, po_valid}, 32'h1);
    end
    checkOutput("basic_busy_cycles", busyCycles - base, 9);

    $display("[TB] handshake and back-to-back");
    po_ready = 1'b1;
    tick();
    checkOutput("consume_valid", {31'd0, po_valid}, 32'h0);
    base = validCycles;
    applyStimulus(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("b2b1_po",    {24'd0, obsPo},    32'h3C);
    checkOutput("b2b1_valid", {31'd0, obsValid}, 32'h1);
    applyStimulus(8'hC3, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("b2b2_po",    {24'd0, obsPo},    32'hC3);
    checkOutput("b2b2_valid", {31'd0, obsValid}, 32'h1);
    tick();
    checkOutput("b2b_valid_after", {31'd0, po_valid}, 32'h0);
    checkOutput("b2b_valid_cycles", validCycles - base, 2);
    checkOutput("b2b_ovr", {31'd0, overrun}, 32'h0);
    po_ready = 1'b0;
    tick();

    $display("[TB] frame table");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k].data, vecs[k].stopBit, vecs[k].rdyAtStop, vecs[k].gap, 1'b0);
      checkOutput($sformatf("vec%0d_po", k),    {24'd0, obsPo},    {24'd0, vecs[k].expPo});
      checkOutput($sformatf("vec%0d_valid", k), {31'd0, obsValid}, {31'd0, vecs[k].expValid});
      checkOutput($sformatf("vec%0d_ovr", k),   {31'd0, obsOvr},   {31'd0, vecs[k].expOvr});
      checkOutput($sformatf("vec%0d_ferr", k),  {31'd0, obsFerr},  {31'd0, vecs[k].expFerr});
      tick();
      checkOutput($sformatf("vec%0d_ferr_next", k), {31'd0, frame_err}, 32'h0);
      checkOutput($sformatf("vec%0d_idle", k),      {31'd0, busy},      32'h0);
      if (vecs[k].clrAfter) begin
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checkOutput($sformatf("vec%0d_clr_ovr", k), {31'd0, overrun}, 32'h0);
      end
      if (vecs[k].consumeAfter) begin
        po_ready = 1'b1;
        tick();
        po_ready = 1'b0;
        checkOutput($sformatf("vec%0d_consumed", k), {31'd0, po_valid}, 32'h0);
      end
    end

    $display("[TB] reset mid-frame");
    sendBit(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) sendBit(i[0], 0, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_po",    {24'd0, po},        32'h0);
    checkOutput("midrst_valid", {31'd0, po_valid},  32'h0);
    checkOutput("midrst_busy",  {31'd0, busy},      32'h0);
    checkOutput("midrst_ovr",   {31'd0, overrun},   32'h0);
    tick();
    checkOutput("midrst_ferr",  {31'd0, frame_err}, 32'h0);
    reset = 1'b1;
    tick();
    applyStimulus(8'h96, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("post_rst_po",     {24'd0, obsPo},     32'h96);
    checkOutput("post_rst_valid",  {31'd0, obsValid},  32'h1);
    checkOutput("post_rst_ferr",   {31'd0, obsFerr},   32'h0);
    checkOutput("msb_rev_po",      {24'd0, obsPo2},    32'h69);
    checkOutput("msb_rev_valid",   {31'd0, obsValid2}, 32'h1);
    po_ready = 1'b1;
    tick();
    po_ready = 1'b0;

    $display("[TB] MSB-first frame");
    applyStimulus(8'h96, 1'b1, 1'b0, 0, 1'b1);
    checkOutput("msb_po",    {24'd0, obsPo2},    32'h96);
    checkOutput("msb_valid", {31'd0, obsValid2}, 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
